dlsc_pcie_cpl_tracker: RTL

//  Parametrised non-posted request tracker for the PCIe root-port bench and RTL requesters.

---
 rtl/dlsc_pcie_pkg.sv | 14 +
 rtl/dlsc_prio_enc.sv | 21 ++
 rtl/dlsc_pcie_cpl_tracker.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dlsc_pcie_pkg.sv
// Shared types for the PCIe completion tracker: per-tag lifecycle states and error kinds.
package dlsc_pcie_pkg;

    typedef enum logic [1:0] {
        TAG_FREE      = 2'd0,
        TAG_BUSY      = 2'd1,
        TAG_EXPIRED   = 2'd2,
        TAG_REPORTING = 2'd3
    } tag_state_e;

    localparam logic ERR_KIND_TIMEOUT    = 1'b0;
    localparam logic ERR_KIND_UNEXPECTED = 1'b1;

endpackage

// File: rtl/dlsc_prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set bit and whether any bit is set.
module dlsc_prio_enc #(
    parameter int WIDTH    = 32,
    parameter int IDX_BITS = 5
) (
    input  logic [WIDTH-1:0]    vec_i,
    output logic [IDX_BITS-1:0] idx_o,
    output logic                found_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = {IDX_BITS{1'b0}};
        found_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            idx_o   = vec_i[i] ? IDX_BITS'(i) : idx_o;
            found_o = found_o | vec_i[i];
        end
    end

endmodule

// File: rtl/dlsc_pcie_cpl_tracker.sv
// Non-posted request tracker: allocates tags, ages them on a prescaled tick and reports
// completion timeouts and unexpected completions through a single handshaked error slot.
module dlsc_pcie_cpl_tracker
    import dlsc_pcie_pkg::*;
#(
    parameter int TAG_BITS      = 5,
    parameter int PRESCALE      = 64,
    parameter int TIMEOUT_TICKS = 78,
    parameter int AGE_BITS      = 7
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                alloc_ready_o,
    input  logic                alloc_valid_i,
    output logic [TAG_BITS-1:0] alloc_tag_o,
    input  logic                cpl_valid_i,
    input  logic [TAG_BITS-1:0] cpl_tag_i,
    input  logic                cpl_last_i,
    output logic                err_valid_o,
    input  logic                err_ready_i,
    output logic [TAG_BITS-1:0] err_tag_o,
    output logic                err_unexpected_o,
    output logic                err_overflow_o,
    output logic [TAG_BITS:0]   outstanding_o
);

    localparam int TAGS       = 1 << TAG_BITS;
    localparam int PRESC_BITS = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    tag_state_e                state_q [TAGS];
    tag_state_e                state_d [TAGS];
    logic [AGE_BITS-1:0]       age_q   [TAGS];
    logic [AGE_BITS-1:0]       age_d   [TAGS];
    logic [PRESC_BITS-1:0]     presc_q, presc_d;
    logic                      err_valid_q, err_valid_d;
    logic [TAG_BITS-1:0]       err_tag_q, err_tag_d;
    logic                      err_unexp_q, err_unexp_d;
    logic                      err_ovf_q, err_ovf_d;
    logic [TAG_BITS:0]         outstanding_q, outstanding_d;

    logic [TAGS-1:0]           free_vec;
    logic [TAGS-1:0]           exp_vec;
    logic [TAG_BITS-1:0]       exp_idx;
    logic                      exp_found;
    logic                      tick;
    logic                      alloc_fire;
    logic                      unexp;
    logic                      slot_open;
    logic                      load_exp;
    logic                      timeout_done;
    logic                      hit;
    logic [TAG_BITS:0]         free_cnt;

    dlsc_prio_enc #(.WIDTH(TAGS), .IDX_BITS(TAG_BITS)) u_free_enc (
        .vec_i   (free_vec),
        .idx_o   (alloc_tag_o),
        .found_o (alloc_ready_o)
    );

    dlsc_prio_enc #(.WIDTH(TAGS), .IDX_BITS(TAG_BITS)) u_exp_enc (
        .vec_i   (exp_vec),
        .idx_o   (exp_idx),
        .found_o (exp_found)
    );

    // Decode registered state into encoder inputs and per-cycle events.
    always_comb begin
        tick       = (presc_q == PRESC_BITS'(PRESCALE - 1));
        alloc_fire = alloc_valid_i && alloc_ready_o;
        unexp      = cpl_valid_i && (state_q[cpl_tag_i] == TAG_FREE);
        slot_open  = !err_valid_q || err_ready_i;
        timeout_done = err_valid_q && err_ready_i && !err_unexp_q;
        for (int t = 0; t < TAGS; t++) begin
            free_vec[t] = (state_q[t] == TAG_FREE);
            // A completion arriving this cycle cancels the tag's expiry, so it must not be reported.
            exp_vec[t]  = (state_q[t] == TAG_EXPIRED) && !(cpl_valid_i && (cpl_tag_i == TAG_BITS'(t)));
        end
    end

    // Error slot: unexpected completions take priority over the lowest expired tag.
    always_comb begin
        err_valid_d = err_valid_q;
        err_tag_d   = err_tag_q;
        err_unexp_d = err_unexp_q;
        err_ovf_d   = err_ovf_q;
        load_exp    = 1'b0;
        if (slot_open) begin
            if (unexp) begin
                err_valid_d = 1'b1;
                err_tag_d   = cpl_tag_i;
                err_unexp_d = ERR_KIND_UNEXPECTED;
            end else if (exp_found) begin
                err_valid_d = 1'b1;
                err_tag_d   = exp_idx;
                err_unexp_d = ERR_KIND_TIMEOUT;
                load_exp    = 1'b1;
            end else begin
                err_valid_d = 1'b0;
            end
        end else begin
            err_ovf_d = err_ovf_q | unexp;
        end
    end

    // Per-tag lifecycle and age counters.
    always_comb begin
        hit = 1'b0;
        for (int t = 0; t < TAGS; t++) begin
            state_d[t] = state_q[t];
            age_d[t]   = age_q[t];
            hit        = cpl_valid_i && (cpl_tag_i == TAG_BITS'(t));
            case (state_q[t])
                TAG_FREE: begin
                    if (alloc_fire && (alloc_tag_o == TAG_BITS'(t))) begin
                        state_d[t] = TAG_BUSY;
                        age_d[t]   = {AGE_BITS{1'b0}};
                    end else begin
                        state_d[t] = TAG_FREE;
                    end
                end
                TAG_BUSY: begin
                    if (hit) begin
                        state_d[t] = cpl_last_i ? TAG_FREE : TAG_BUSY;
                        age_d[t]   = {AGE_BITS{1'b0}};
                    end else if (tick && (age_q[t] < AGE_BITS'(TIMEOUT_TICKS))) begin
                        age_d[t]   = age_q[t] + AGE_BITS'(1);
                        state_d[t] = (age_q[t] + AGE_BITS'(1) == AGE_BITS'(TIMEOUT_TICKS)) ? TAG_EXPIRED : TAG_BUSY;
                    end else begin
                        state_d[t] = TAG_BUSY;
                    end
                end
                TAG_EXPIRED: begin
                    if (hit) begin
                        state_d[t] = cpl_last_i ? TAG_FREE : TAG_BUSY;
                        age_d[t]   = {AGE_BITS{1'b0}};
                    end else if (load_exp && (exp_idx == TAG_BITS'(t))) begin
                        state_d[t] = TAG_REPORTING;
                    end else begin
                        state_d[t] = TAG_EXPIRED;
                    end
                end
                TAG_REPORTING: begin
                    if (timeout_done && (err_tag_q == TAG_BITS'(t))) begin
                        state_d[t] = TAG_FREE;
                        age_d[t]   = {AGE_BITS{1'b0}};
                    end else begin
                        state_d[t] = TAG_REPORTING;
                    end
                end
                default: begin
                    state_d[t] = TAG_FREE;
                    age_d[t]   = {AGE_BITS{1'b0}};
                end
            endcase
        end
    end

    // Prescaler wrap and the next-cycle outstanding count.
    always_comb begin
        presc_d  = tick ? {PRESC_BITS{1'b0}} : presc_q + PRESC_BITS'(1);
        free_cnt = {(TAG_BITS + 1){1'b0}};
        for (int t = 0; t < TAGS; t++) begin
            free_cnt = free_cnt + ((state_d[t] == TAG_FREE) ? (TAG_BITS + 1)'(1) : (TAG_BITS + 1)'(0));
        end
        outstanding_d = (TAG_BITS + 1)'(TAGS) - free_cnt;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int t = 0; t < TAGS; t++) begin
                state_q[t] <= TAG_FREE;
                age_q[t]   <= {AGE_BITS{1'b0}};
            end
            presc_q       <= {PRESC_BITS{1'b0}};
            err_valid_q   <= 1'b0;
            err_tag_q     <= {TAG_BITS{1'b0}};
            err_unexp_q   <= 1'b0;
            err_ovf_q     <= 1'b0;
            outstanding_q <= {(TAG_BITS + 1){1'b0}};
        end else begin
            for (int t = 0; t < TAGS; t++) begin
                state_q[t] <= state_d[t];
                age_q[t]   <= age_d[t];
            end
            presc_q       <= presc_d;
            err_valid_q   <= err_valid_d;
            err_tag_q     <= err_tag_d;
            err_unexp_q   <= err_unexp_d;
            err_ovf_q     <= err_ovf_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign err_valid_o      = err_valid_q;
    assign err_tag_o        = err_tag_q;
    assign err_unexpected_o = err_unexp_q;
    assign err_overflow_o   = err_ovf_q;
    assign outstanding_o    = outstanding_q;

endmodule
